// File: rtl/jericalla_pkg.sv
// Shared types, constants and field helpers for the jericalla instruction sequencer.
// Word layout (bit 0 is the MSB): [0:4] RA2, [5:9] RA1, [10:14] WA, [15:17] opcode.
package jericalla_pkg;

  localparam int unsigned WORD_W  = 18;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned STALL_W = 16;

  localparam int unsigned RA2_FIRST = 0;
  localparam int unsigned RA2_LAST  = 4;
  localparam int unsigned RA1_FIRST = 5;
  localparam int unsigned RA1_LAST  = 9;
  localparam int unsigned WA_FIRST  = 10;
  localparam int unsigned WA_LAST   = 14;
  localparam int unsigned OP_FIRST  = 15;
  localparam int unsigned OP_LAST   = 17;

  typedef logic [0:WORD_W-1] word_t;

  localparam logic [OP_W-1:0] OP_STORE = 3'b101;
  localparam logic [OP_W-1:0] OP_LOAD  = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP   = 3'b111;

  localparam word_t NOP_WORD  = 18'h00007;
  localparam word_t HALT_WORD = 18'h3FFFF;

  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [REG_W-1:0] get_ra2(input word_t w);
    return w[RA2_FIRST:RA2_LAST];
  endfunction

  function automatic logic [REG_W-1:0] get_ra1(input word_t w);
    return w[RA1_FIRST:RA1_LAST];
  endfunction

  function automatic logic [REG_W-1:0] get_wa(input word_t w);
    return w[WA_FIRST:WA_LAST];
  endfunction

  function automatic logic [OP_W-1:0] get_op(input word_t w);
    return w[OP_FIRST:OP_LAST];
  endfunction

  // Only the ALU opcodes (000..100) write the register bank.
  function automatic logic writes_br(input logic [OP_W-1:0] op);
    return (op != OP_STORE) && (op != OP_LOAD) && (op != OP_NOP);
  endfunction

endpackage

// File: rtl/secuenciador_jericalla_detector.sv
// Read-after-write hazard compare of the fetch candidate against the two
// instructions still in flight (stage 0 and buffer 1).
module detector_riesgos
  import jericalla_pkg::*;
(
  input  word_t cand,
  input  word_t instr,
  input  word_t hist1,
  output logic  hazard_c
);

  function automatic logic conflicts(input word_t c, input word_t x);
    return writes_br(get_op(x)) &&
           ((get_ra1(c) == get_wa(x)) || (get_ra2(c) == get_wa(x)));
  endfunction

  always_comb begin
    hazard_c = 1'b0;
    if (conflicts(cand, instr) || conflicts(cand, hist1)) begin
      hazard_c = 1'b1;
    end
  end

endmodule

// File: rtl/secuenciador_jericalla.sv
// Instruction sequencer: program memory, PC and run FSM that issues words to the
// jericalla datapath, inserting NOP bubbles on RAW hazards and draining on HALT.
module secuenciador_jericalla
  import jericalla_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_jericalla,
  input  logic          rst_jericalla,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [0:17]   prog_data,
  output logic [0:17]   instruccion,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);

  state_t               state_q, state_d;
  word_t                instr_q, instr_d;
  word_t                hist1_q, hist1_d;
  logic [AW-1:0]        pc_q, pc_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic [1:0]           drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  word_t                imem [DEPTH];
  word_t                cand;
  logic                 hazard_c;

  assign cand = imem[pc_q];

  detector_riesgos u_detector (
    .cand     (cand),
    .instr    (instr_q),
    .hist1    (hist1_q),
    .hazard_c (hazard_c)
  );

  // Program memory is not reset; loading is only allowed while idle.
  always_ff @(posedge clk_jericalla) begin
    if (!rst_jericalla && prog_we && (state_q == IDLE)) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk_jericalla) begin
    if (rst_jericalla) begin
      state_q <= IDLE;
      instr_q <= NOP_WORD;
      hist1_q <= NOP_WORD;
      pc_q    <= '0;
      stall_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      hist1_q <= hist1_d;
      pc_q    <= pc_d;
      stall_q <= stall_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = NOP_WORD;
    hist1_d = instr_q;
    pc_d    = pc_q;
    stall_d = stall_q;
    drain_d = drain_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pc_d    = '0;
          stall_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hazard_c) begin
          if (stall_q != {STALL_W{1'b1}}) begin
            stall_d = stall_q + STALL_W'(1);
          end
        end else begin
          instr_d = cand;
          // HALT or the last memory word ends the program; pc stays put.
          if ((cand == HALT_WORD) || (pc_q == AW'(DEPTH - 1))) begin
            state_d = DRAIN;
            drain_d = DRAIN_CYCLES;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  assign instruccion = instr_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_secuenciador_jericalla.sv
// Directed self-checking bench for secuenciador_jericalla.
module tb_secuenciador_jericalla;

  logic        clk_jericalla = 1'b0;
  logic        rst_jericalla;
  logic        start;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [0:17] prog_data;
  logic [0:17] instruccion;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [0:17] NOP  = 18'h00007;
  localparam logic [0:17] HALT = 18'h3FFFF;

  secuenciador_jericalla dut (
    .clk_jericalla (clk_jericalla),
    .rst_jericalla (rst_jericalla),
    .start         (start),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .instruccion   (instruccion),
    .pc            (pc),
    .busy          (busy),
    .done          (done),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk_jericalla = ~clk_jericalla;

  function automatic logic [0:17] mk(input logic [4:0] ra2, input logic [4:0] ra1,
                                     input logic [4:0] wa, input logic [2:0] op);
    return {ra2, ra1, wa, op};
  endfunction

  task automatic tick();
    @(posedge clk_jericalla);
    #1;
  endtask

  task automatic do_reset();
    rst_jericalla = 1'b1;
    tick();
    rst_jericalla = 1'b0;
  endtask

  task automatic write_word(input logic [4:0] a, input logic [0:17] d, input logic with_start);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    start     = with_start;
    tick();
    prog_we   = 1'b0;
    start     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs n issue cycles after start, comparing instruccion and pc per cycle.
  task automatic run_trace(input string name, input int n,
                           input logic [0:17] exp_i [8], input logic [4:0] exp_pc [8]);
    for (int k = 0; k < n; k++) begin
      tick();
      checks++;
      if (instruccion !== exp_i[k]) begin
        failures++;
        $display("FAIL %s instr cyc%0d got=%h exp=%h", name, k + 1, instruccion, exp_i[k]);
      end
      checks++;
      if (pc !== exp_pc[k]) begin
        failures++;
        $display("FAIL %s pc cyc%0d got=%0d exp=%0d", name, k + 1, pc, exp_pc[k]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (instruccion !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruccion, NOP); end
    if (pc !== 5'd0)         begin failures++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_independent();
    logic [0:17] ei [8];
    logic [4:0]  ep [8];
    logic [0:17] a, b;
    a = mk(5'd2, 5'd1, 5'd3, 3'b000);
    b = mk(5'd6, 5'd5, 5'd4, 3'b001);
    do_reset();
    write_word(5'd0, a, 1'b0);
    write_word(5'd1, b, 1'b0);
    write_word(5'd2, HALT, 1'b1);  // write and start in the same cycle
    checks++;
    if (busy !== 1'b1 || instruccion !== NOP) begin
      failures++; $display("FAIL indep_start busy=%b instr=%h exp busy=1 instr=%h", busy, instruccion, NOP);
    end
    ei = '{a, b, HALT, NOP, NOP, NOP, NOP, NOP};
    ep = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
    run_trace("indep", 5, ei, ep);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL indep_done_early got=%b exp=0", done); end
    tick();
    checks += 3;
    if (done !== 1'b1)       begin failures++; $display("FAIL indep_done got=%b exp=1", done); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL indep_busy got=%b exp=0", busy); end
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL indep_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [0:17] ei [8];
    logic [4:0]  ep [8];
    logic [0:17] w, r;
    w = mk(5'd0, 5'd0, 5'd3, 3'b000);
    r = mk(5'd0, 5'd3, 5'd5, 3'b010);
    do_reset();
    write_word(5'd0, w, 1'b0);
    write_word(5'd1, r, 1'b0);
    write_word(5'd2, HALT, 1'b0);
    pulse_start();
    ei = '{w, NOP, NOP, r, HALT, NOP, NOP, NOP};
    ep = '{5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
    run_trace("b2b", 8, ei, ep);
    checks += 2;
    if (stall_cnt !== 16'd2) begin failures++; $display("FAIL b2b_stall got=%0d exp=2", stall_cnt); end
    if (done !== 1'b1)       begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
  endtask

  task automatic test_distance2();
    logic [0:17] ei [8];
    logic [4:0]  ep [8];
    logic [0:17] w, i, r;
    w = mk(5'd0, 5'd0, 5'd3, 3'b000);
    i = mk(5'd1, 5'd2, 5'd4, 3'b011);
    r = mk(5'd3, 5'd0, 5'd6, 3'b000);
    do_reset();
    write_word(5'd0, w, 1'b0);
    write_word(5'd1, i, 1'b0);
    write_word(5'd2, r, 1'b0);
    write_word(5'd3, HALT, 1'b0);
    pulse_start();
    ei = '{w, i, NOP, r, HALT, NOP, NOP, NOP};
    ep = '{5'd1, 5'd2, 5'd2, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3};
    run_trace("dist2", 5, ei, ep);
    checks++;
    if (stall_cnt !== 16'd1) begin failures++; $display("FAIL dist2_stall got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_store_no_stall();
    logic [0:17] ei [8];
    logic [4:0]  ep [8];
    logic [0:17] s, r;
    s = mk(5'd0, 5'd0, 5'd3, 3'b101);
    r = mk(5'd3, 5'd0, 5'd6, 3'b000);
    do_reset();
    write_word(5'd0, s, 1'b0);
    write_word(5'd1, r, 1'b0);
    write_word(5'd2, HALT, 1'b0);
    pulse_start();
    ei = '{s, r, HALT, NOP, NOP, NOP, NOP, NOP};
    ep = '{5'd1, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2};
    run_trace("store", 3, ei, ep);
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL store_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_program_end_restart();
    logic [0:17] prog [32];
    int          waited;
    logic        seen;
    for (int k = 0; k < 32; k++) prog[k] = mk(5'd2, 5'd1, 5'd7, 3'(k % 5));
    prog[1] = mk(5'd2, 5'd7, 5'd7, 3'b000);  // reads what word 0 writes
    do_reset();
    for (int k = 0; k < 32; k++) write_word(5'(k), prog[k], 1'b0);
    pulse_start();
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 4) begin
        checks++;
        if (instruccion !== prog[1] || pc !== 5'd2) begin
          failures++; $display("FAIL end_w1 instr=%h pc=%0d exp instr=%h pc=2", instruccion, pc, prog[1]);
        end
      end
    end
    checks += 2;
    if (instruccion !== prog[31]) begin failures++; $display("FAIL end_w31 got=%h exp=%h", instruccion, prog[31]); end
    if (pc !== 5'd31)             begin failures++; $display("FAIL end_pc got=%0d exp=31", pc); end
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      waited++;
      seen = done;
    end
    checks += 3;
    if (!seen || waited != 3) begin failures++; $display("FAIL end_done_lat got=%0d exp=3", waited); end
    if (stall_cnt !== 16'd2)  begin failures++; $display("FAIL end_stall got=%0d exp=2", stall_cnt); end
    if (pc !== 5'd31)         begin failures++; $display("FAIL end_pc_hold got=%0d exp=31", pc); end

    write_word(5'd5, HALT, 1'b0);  // ignored in DONE
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL done_hold got=%b exp=1", done); end
    pulse_start();
    checks += 4;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL restart_stall got=%0d exp=0", stall_cnt); end
    if (pc !== 5'd0)         begin failures++; $display("FAIL restart_pc got=%0d exp=0", pc); end
    if (busy !== 1'b1)       begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL restart_done got=%b exp=0", done); end
    tick();
    checks++;
    if (instruccion !== prog[0]) begin failures++; $display("FAIL restart_w0 got=%h exp=%h", instruccion, prog[0]); end
    write_word(5'd10, HALT, 1'b0);  // ignored while busy
    tick();
    tick();

    rst_jericalla = 1'b1;
    tick();
    rst_jericalla = 1'b0;
    checks += 5;
    if (instruccion !== NOP) begin failures++; $display("FAIL midrst_instr got=%h exp=%h", instruccion, NOP); end
    if (pc !== 5'd0)         begin failures++; $display("FAIL midrst_pc got=%0d exp=0", pc); end
    if (busy !== 1'b0)       begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL midrst_done got=%b exp=0", done); end
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL midrst_stall got=%0d exp=0", stall_cnt); end
    tick();
    checks++;
    if (instruccion !== NOP || busy !== 1'b0) begin
      failures++; $display("FAIL midrst_idle instr=%h busy=%b exp instr=%h busy=0", instruccion, busy, NOP);
    end

    // Untouched memory means the full 32-word program runs again to the end.
    pulse_start();
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      seen = done;
    end
    checks += 3;
    if (!seen)               begin failures++; $display("FAIL mem_rerun_timeout done=%b exp=1", done); end
    if (pc !== 5'd31)        begin failures++; $display("FAIL mem_unchanged pc got=%0d exp=31", pc); end
    if (stall_cnt !== 16'd2) begin failures++; $display("FAIL mem_rerun_stall got=%0d exp=2", stall_cnt); end
  endtask

  initial begin
    rst_jericalla = 1'b1;
    start         = 1'b0;
    prog_we       = 1'b0;
    prog_addr     = '0;
    prog_data     = '0;
    test_reset();
    test_independent();
    test_back_to_back();
    test_distance2();
    test_store_no_stall();
    test_program_end_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
